// File: rtl/csr_unit.sv
// Machine-mode CSR unit: trap CSRs, 64-bit cycle/instret/hpm counters,
// CSR read-modify-write, trap entry and mret for the veriRISCV MEM stage.
module csr_unit #(
    parameter int          NUM_MHPM    = 2,
    parameter logic [31:0] HART_ID     = 32'h0,
    parameter logic [31:0] MTVEC_RESET = 32'h0,
    parameter logic [31:0] MISA_VALUE  = 32'h40000100
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   csr_read,
    input  logic                                   csr_write,
    input  logic [1:0]                             csr_opcode,
    input  logic [11:0]                            csr_address,
    input  logic [31:0]                            csr_writedata,
    output logic [31:0]                            csr_readdata,
    output logic                                   csr_illegal,
    input  logic                                   trap,
    input  logic                                   trap_interrupt,
    input  logic [30:0]                            trap_cause,
    input  logic [31:0]                            trap_pc,
    input  logic [31:0]                            trap_tval,
    input  logic                                   mret,
    input  logic                                   instret,
    input  logic [((NUM_MHPM > 0) ? NUM_MHPM : 1)-1:0] hpm_event,
    input  logic                                   sw_irq,
    input  logic                                   timer_irq,
    input  logic                                   ext_irq,
    output logic                                   irq_pending,
    output logic [31:0]                            o_trap_vector,
    output logic [31:0]                            o_mepc,
    output logic                                   o_mstatus_mie
);

    localparam int          HPM_N     = (NUM_MHPM > 0) ? NUM_MHPM : 1;
    localparam logic [31:0] MIE_MASK  = 32'h0000_0888;
    localparam logic [31:0] INH_MASK  = 32'h5 | (((32'h1 << NUM_MHPM) - 32'h1) << 3);

    logic        r_mstatus_mie;
    logic        r_mstatus_mpie;
    logic [31:0] r_mie;
    logic [31:0] r_mtvec;
    logic [31:0] r_mcountinhibit;
    logic [31:0] r_mscratch;
    logic [31:0] r_mepc;
    logic [31:0] r_mcause;
    logic [31:0] r_mtval;
    logic [63:0] r_mcycle;
    logic [63:0] r_minstret;
    logic [63:0] r_mhpm [HPM_N];

    logic [31:0]      w_mip;
    logic [31:0]      w_mstatus;
    logic [31:0]      w_rdata;
    logic             w_mapped;
    logic             w_we;
    logic [31:0]      w_wdata;
    logic [31:0]      w_vec_base;
    logic [HPM_N-1:0] w_hpm_wr_lo;
    logic [HPM_N-1:0] w_hpm_wr_hi;
    logic             w_cy_wr_lo, w_cy_wr_hi, w_ir_wr_lo, w_ir_wr_hi;

    assign w_mip     = {20'b0, ext_irq, 3'b0, timer_irq, 3'b0, sw_irq, 3'b0};
    assign w_mstatus = {19'b0, 2'b11, 3'b0, r_mstatus_mpie, 3'b0, r_mstatus_mie, 3'b0};

    // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
    always_comb begin
        w_rdata  = '0;
        w_mapped = 1'b1;
        case (csr_address)
            12'h300:                   w_rdata = w_mstatus;
            12'h301:                   w_rdata = MISA_VALUE;
            12'h304:                   w_rdata = r_mie;
            12'h305:                   w_rdata = r_mtvec;
            12'h320:                   w_rdata = r_mcountinhibit;
            12'h340:                   w_rdata = r_mscratch;
            12'h341:                   w_rdata = r_mepc;
            12'h342:                   w_rdata = r_mcause;
            12'h343:                   w_rdata = r_mtval;
            12'h344:                   w_rdata = w_mip;
            12'hB00, 12'hC00:          w_rdata = r_mcycle[31:0];
            12'hB80, 12'hC80:          w_rdata = r_mcycle[63:32];
            12'hB02, 12'hC02:          w_rdata = r_minstret[31:0];
            12'hB82, 12'hC82:          w_rdata = r_minstret[63:32];
            12'hF11, 12'hF12, 12'hF13: w_rdata = '0;
            12'hF14:                   w_rdata = HART_ID;
            default: begin
                w_mapped = 1'b0;
                for (int i = 0; i < NUM_MHPM; i++) begin
                    if (csr_address == 12'hB03 + 12'(i) || csr_address == 12'hC03 + 12'(i)) begin
                        w_rdata  = r_mhpm[i][31:0];
                        w_mapped = 1'b1;
                    end
                    if (csr_address == 12'hB83 + 12'(i) || csr_address == 12'hC83 + 12'(i)) begin
                        w_rdata  = r_mhpm[i][63:32];
                        w_mapped = 1'b1;
                    end
                end
            end
        endcase
    end

    assign csr_illegal  = ((csr_read | csr_write) & ~w_mapped) |
                          (csr_write & (csr_address[11:10] == 2'b11));
    assign csr_readdata = csr_read ? w_rdata : 32'h0;
    assign w_we         = csr_write & ~csr_illegal & ~trap & ~mret;

    always_comb begin
        case (csr_opcode)
            2'b10:   w_wdata = w_rdata | csr_writedata;
            2'b11:   w_wdata = w_rdata & ~csr_writedata;
            default: w_wdata = csr_writedata;
        endcase
    end

    assign w_cy_wr_lo = w_we & (csr_address == 12'hB00);
    assign w_cy_wr_hi = w_we & (csr_address == 12'hB80);
    assign w_ir_wr_lo = w_we & (csr_address == 12'hB02);
    assign w_ir_wr_hi = w_we & (csr_address == 12'hB82);

    always_comb begin
        w_hpm_wr_lo = '0;
        w_hpm_wr_hi = '0;
        for (int i = 0; i < NUM_MHPM; i++) begin
            w_hpm_wr_lo[i] = w_we & (csr_address == 12'hB03 + 12'(i));
            w_hpm_wr_hi[i] = w_we & (csr_address == 12'hB83 + 12'(i));
        end
    end

    // Trap beats mret, which beats a CSR write (w_we already excludes both).
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mstatus_mie   <= 1'b0;
            r_mstatus_mpie  <= 1'b0;
            r_mie           <= '0;
            r_mtvec         <= MTVEC_RESET & ~32'h2;
            r_mcountinhibit <= '0;
            r_mscratch      <= '0;
            r_mepc          <= '0;
            r_mcause        <= '0;
            r_mtval         <= '0;
        end else if (trap) begin
            r_mepc         <= trap_pc & ~32'h3;
            r_mcause       <= {trap_interrupt, trap_cause};
            r_mtval        <= trap_tval;
            r_mstatus_mpie <= r_mstatus_mie;
            r_mstatus_mie  <= 1'b0;
        end else if (mret) begin
            r_mstatus_mie  <= r_mstatus_mpie;
            r_mstatus_mpie <= 1'b1;
        end else if (w_we) begin
            case (csr_address)
                12'h300: begin
                    r_mstatus_mie  <= w_wdata[3];
                    r_mstatus_mpie <= w_wdata[7];
                end
                12'h304: r_mie           <= w_wdata & MIE_MASK;
                12'h305: r_mtvec         <= w_wdata & ~32'h2;
                12'h320: r_mcountinhibit <= w_wdata & INH_MASK;
                12'h340: r_mscratch      <= w_wdata;
                12'h341: r_mepc          <= w_wdata & ~32'h3;
                12'h342: r_mcause        <= w_wdata;
                12'h343: r_mtval         <= w_wdata;
                default: ;
            endcase
        end
    end

    // A write to either half of a counter freezes the other half for that cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mcycle   <= '0;
            r_minstret <= '0;
        end else begin
            if (w_cy_wr_lo || w_cy_wr_hi) begin
                if (w_cy_wr_lo) r_mcycle[31:0]  <= w_wdata;
                if (w_cy_wr_hi) r_mcycle[63:32] <= w_wdata;
            end else if (!r_mcountinhibit[0]) begin
                r_mcycle <= r_mcycle + 64'd1;
            end
            if (w_ir_wr_lo || w_ir_wr_hi) begin
                if (w_ir_wr_lo) r_minstret[31:0]  <= w_wdata;
                if (w_ir_wr_hi) r_minstret[63:32] <= w_wdata;
            end else if (instret && !r_mcountinhibit[2]) begin
                r_minstret <= r_minstret + 64'd1;
            end
        end
    end

    // NOTE: the counter array is architectural state, so it is reset in full rather than left like a RAM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < HPM_N; i++) r_mhpm[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_MHPM; i++) begin
                if (w_hpm_wr_lo[i] || w_hpm_wr_hi[i]) begin
                    if (w_hpm_wr_lo[i]) r_mhpm[i][31:0]  <= w_wdata;
                    if (w_hpm_wr_hi[i]) r_mhpm[i][63:32] <= w_wdata;
                end else if (hpm_event[i] && !r_mcountinhibit[3+i]) begin
                    r_mhpm[i] <= r_mhpm[i] + 64'd1;
                end
            end
        end
    end

    assign w_vec_base    = {r_mtvec[31:2], 2'b00};
    assign o_trap_vector = (r_mtvec[0] && trap_interrupt) ?
                           w_vec_base + {trap_cause[29:0], 2'b00} : w_vec_base;
    assign o_mepc        = r_mepc;
    assign o_mstatus_mie = r_mstatus_mie;
    assign irq_pending   = r_mstatus_mie & |(w_mip & r_mie);

endmodule
